// File: rtl/spi_cfg_tx_if.sv
// spi_cfg_tx_if: request/status and SPI wire bundle for spi_cfg_tx.
// Optional trig_only field exists only with SPI_TX_TRIG_ONLY_EN defined.
//
// Signals
//   start     request a frame (accepted only while busy=0)
//   trig      trigger bit, first bit on the wire
//   adsr_*    attack/decay increments, sustain level, release increment (8b)
//   osc_count oscillator period count (12b)
//   filter_*  filter coefficients a/b (8b)
//   trig_only send the trigger bit only (SPI_TX_TRIG_ONLY_EN builds)
//   busy      transmitter not idle
//   done      one-cycle pulse when a frame has fully completed
//   sclk      SPI clock, idle low
//   nss       frame select, active low
//   mosi      serial data
// Modports: slave = transmitter side, master = requester/observer side.
interface spi_cfg_tx_if;
    logic        start;
    logic        trig;
    logic [7:0]  adsr_ai;
    logic [7:0]  adsr_di;
    logic [7:0]  adsr_s;
    logic [7:0]  adsr_ri;
    logic [11:0] osc_count;
    logic [7:0]  filter_a;
    logic [7:0]  filter_b;
`ifdef SPI_TX_TRIG_ONLY_EN
    logic        trig_only;
`endif
    logic        busy;
    logic        done;
    logic        sclk;
    logic        nss;
    logic        mosi;

    modport slave (
`ifdef SPI_TX_TRIG_ONLY_EN
        input  trig_only,
`endif
        input  start, trig,
        input  adsr_ai, adsr_di, adsr_s, adsr_ri,
        input  osc_count, filter_a, filter_b,
        output busy, done, sclk, nss, mosi
    );

    modport master (
`ifdef SPI_TX_TRIG_ONLY_EN
        output trig_only,
`endif
        output start, trig,
        output adsr_ai, adsr_di, adsr_s, adsr_ri,
        output osc_count, filter_a, filter_b,
        input  busy, done, sclk, nss, mosi
    );
endinterface

// File: rtl/spi_cfg_tx.sv
// spi_cfg_tx: SPI master shifting one 61-bit synth configuration frame
// {trig, filter_b, filter_a, osc_count, adsr_ri, adsr_s, adsr_di, adsr_ai}
// MSB first. Optional feature macro: SPI_TX_TRIG_ONLY_EN (1-bit trigger
// frames selected by bus.trig_only).
//
// Ports
//   clk    system clock, rising edge
//   arstn  asynchronous active-low reset
//   bus    spi_cfg_tx_if.slave: start/fields in, busy/done/sclk/nss/mosi out
// Parameters
//   CLK_DIV    sclk half-period in clk cycles (>=1)
//   GAP_CYCLES minimum nss-high cycles between frames (>=1)
module spi_cfg_tx #(
    parameter int CLK_DIV    = 4,
    parameter int GAP_CYCLES = 8
) (
    input  logic        clk,
    input  logic        arstn,
    spi_cfg_tx_if.slave bus
);

    localparam int FW = 61;
    localparam int DW = $clog2(CLK_DIV + 1);
    localparam int GW = $clog2(GAP_CYCLES + 1);

    localparam logic [DW-1:0] DIV_LOAD = DW'(CLK_DIV - 1);
    // The IDLE cycle that follows GAP also keeps nss high, so GAP itself
    // lasts one cycle less than the required gap.
    localparam logic [GW-1:0] GAP_LOAD =
        GW'((GAP_CYCLES > 1) ? GAP_CYCLES - 2 : 0);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        HIGH,
        LOW,
        HOLD,
        GAP
    } state_t;

    state_t        state_q, state_d;
    logic [DW-1:0] div_q, div_d;
    logic [GW-1:0] gcnt_q, gcnt_d;
    logic [5:0]    bitcnt_q, bitcnt_d;
    logic [FW-1:0] shreg_q, shreg_d;

    logic sclk_q, sclk_d;
    logic nss_q, nss_d;
    logic mosi_q, mosi_d;
    logic busy_q, busy_d;
    logic done_q, done_d;

    logic [FW-1:0] frame;
    logic [5:0]    first_cnt;
    logic          phase_end;
    logic          in_frame;

    always_comb begin
        frame = {bus.trig, bus.filter_b, bus.filter_a, bus.osc_count,
                 bus.adsr_ri, bus.adsr_s, bus.adsr_di, bus.adsr_ai};
`ifdef SPI_TX_TRIG_ONLY_EN
        first_cnt = bus.trig_only ? 6'd0 : 6'(FW - 1);
`else
        first_cnt = 6'(FW - 1);
`endif
    end

    // State and counter registers. Outputs are registered from their
    // next-state values so sclk/nss/mosi never glitch.
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            state_q  <= IDLE;
            div_q    <= '0;
            gcnt_q   <= '0;
            bitcnt_q <= '0;
            shreg_q  <= '0;
            sclk_q   <= 1'b0;
            nss_q    <= 1'b1;
            mosi_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            div_q    <= div_d;
            gcnt_q   <= gcnt_d;
            bitcnt_q <= bitcnt_d;
            shreg_q  <= shreg_d;
            sclk_q   <= sclk_d;
            nss_q    <= nss_d;
            mosi_q   <= mosi_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d   = state_q;
        div_d     = div_q;
        gcnt_d    = gcnt_q;
        bitcnt_d  = bitcnt_q;
        shreg_d   = shreg_q;
        phase_end = (div_q == '0);

        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d  = SETUP;
                    shreg_d  = frame;
                    bitcnt_d = first_cnt;
                end
            end
            SETUP: begin
                if (phase_end) state_d = HIGH;
            end
            HIGH: begin
                if (phase_end) begin
                    if (bitcnt_q != 6'd0) begin
                        // next bit appears on mosi from the first LOW cycle
                        state_d  = LOW;
                        shreg_d  = {shreg_q[FW-2:0], 1'b0};
                        bitcnt_d = bitcnt_q - 6'd1;
                    end else begin
                        state_d = HOLD;
                    end
                end
            end
            LOW: begin
                if (phase_end) state_d = HIGH;
            end
            HOLD: begin
                if (phase_end) begin
                    state_d = (GAP_CYCLES > 1) ? GAP : IDLE;
                end
            end
            GAP: begin
                if (gcnt_q == '0) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // every phase change restarts both timers
        if (state_d != state_q) begin
            div_d  = DIV_LOAD;
            gcnt_d = GAP_LOAD;
        end else begin
            if (div_q != '0)  div_d  = div_q - 1'b1;
            if (gcnt_q != '0) gcnt_d = gcnt_q - 1'b1;
        end
    end

    // Output decode of the upcoming state
    always_comb begin
        in_frame = (state_d == SETUP) || (state_d == HIGH) ||
                   (state_d == LOW)   || (state_d == HOLD);
        sclk_d   = (state_d == HIGH);
        nss_d    = !in_frame;
        mosi_d   = in_frame && shreg_d[FW-1];
        busy_d   = (state_d != IDLE);
        done_d   = (state_d == IDLE) && (state_q != IDLE);
    end

    assign bus.sclk = sclk_q;
    assign bus.nss  = nss_q;
    assign bus.mosi = mosi_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;

endmodule

// File: tb/tb_spi_cfg_tx.sv
// tb_spi_cfg_tx: directed + random frames for spi_cfg_tx, checked
// against a receiver model that decodes the SPI wire.
module tb_spi_cfg_tx;

    localparam int CLK_DIV = 4;
    localparam int GAP     = 8;
    localparam int FW      = 61;

    logic clk = 1'b0;
    logic arstn;

    always #5 clk = ~clk;

    spi_cfg_tx_if b();

    spi_cfg_tx #(
        .CLK_DIV    (CLK_DIV),
        .GAP_CYCLES (GAP)
    ) dut (
        .clk   (clk),
        .arstn (arstn),
        .bus   (b)
    );

    int checks = 0;
    int errors = 0;

    // receiver / wire monitor state
    logic        prev_sclk = 1'b0;
    logic        prev_nss  = 1'b1;
    logic        prev_mosi = 1'b0;
    logic        prev_busy = 1'b0;
    logic [60:0] rx_sh     = '0;
    logic [60:0] last_val  = '0;
    logic        rx_trig   = 1'b0;
    logic [59:0] rx_cfg    = '0;
    int edges        = 0;
    int nss_low      = 0;
    int hi_cnt       = 0;
    int last_len     = 0;
    int last_low     = 0;
    int last_gap     = 0;
    int frames       = 0;
    int done_cnt     = 0;
    int busy_lo      = 0;
    int last_busy_lo = 0;
    int viol         = 0;

    always @(negedge clk) begin
        if (!b.nss && prev_nss) begin
            last_gap = hi_cnt;
            hi_cnt   = 0;
            edges    = 0;
            nss_low  = 0;
            rx_sh    = '0;
        end
        if (b.nss && !prev_nss) begin
            last_len = edges;
            last_low = nss_low;
            last_val = rx_sh;
            frames++;
            hi_cnt = 0;
            if (edges == FW) begin
                rx_trig = rx_sh[60];
                rx_cfg  = rx_sh[59:0];
            end else if (edges == 1) begin
                rx_trig = rx_sh[0];
            end
        end
        if (!b.nss) nss_low++;
        else hi_cnt++;
        if (b.sclk && !prev_sclk && !b.nss) begin
            rx_sh = {rx_sh[59:0], b.mosi};
            edges++;
        end
        if (b.sclk && prev_sclk && (b.mosi !== prev_mosi)) viol++;
        if (b.done) done_cnt++;
        if (b.busy && !prev_busy) begin
            last_busy_lo = busy_lo;
            busy_lo = 0;
        end
        if (!b.busy) busy_lo++;
        prev_sclk = b.sclk;
        prev_nss  = b.nss;
        prev_mosi = b.mosi;
        prev_busy = b.busy;
    end

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #2;
    endtask

    // expected wire word built field by field, first-sent field on top
    function automatic logic [63:0] cur_word();
        logic [63:0] w;
        w = 64'(b.trig);
        w = (w << 8)  | 64'(b.filter_b);
        w = (w << 8)  | 64'(b.filter_a);
        w = (w << 12) | 64'(b.osc_count);
        w = (w << 8)  | 64'(b.adsr_ri);
        w = (w << 8)  | 64'(b.adsr_s);
        w = (w << 8)  | 64'(b.adsr_di);
        w = (w << 8)  | 64'(b.adsr_ai);
        return w;
    endfunction

    task automatic rand_fields();
        b.trig      = 1'($urandom);
        b.adsr_ai   = 8'($urandom);
        b.adsr_di   = 8'($urandom);
        b.adsr_s    = 8'($urandom);
        b.adsr_ri   = 8'($urandom);
        b.osc_count = 12'($urandom);
        b.filter_a  = 8'($urandom);
        b.filter_b  = 8'($urandom);
    endtask

    task automatic wait_done(input string tag, input int dn0);
        int n = 0;
        while (done_cnt == dn0 && n < 3000) begin
            tick();
            n++;
        end
        check({tag, "_done_seen"}, 64'(done_cnt != dn0), 64'd1);
    endtask

    task automatic wait_edges(input string tag, input int k);
        int n = 0;
        while (edges < k && n < 3000) begin
            tick();
            n++;
        end
        check({tag, "_edges_reached"}, 64'(edges >= k), 64'd1);
    endtask

    task automatic check_frame(input string tag, input logic [63:0] exp,
                               input int nbits);
        check({tag, "_edges"}, 64'(last_len), 64'(nbits));
        check({tag, "_nss_low"}, 64'(last_low),
              64'(CLK_DIV * (2 * nbits + 1)));
        if (nbits == FW) begin
            check({tag, "_wire"}, 64'(last_val), exp);
            check({tag, "_rx_cfg"}, 64'({rx_trig, rx_cfg}), exp);
        end
    endtask

    task automatic send_and_check(input string tag);
        logic [63:0] exp;
        int fr0;
        int dn0;
        exp = cur_word();
        fr0 = frames;
        dn0 = done_cnt;
        b.start = 1'b1;
        tick();
        b.start = 1'b0;
        wait_done(tag, dn0);
        check({tag, "_frames"}, 64'(frames), 64'(fr0 + 1));
        check_frame(tag, exp, FW);
        tick();
        check({tag, "_done_pulse"}, 64'(b.done), 64'd0);
        check({tag, "_done_once"}, 64'(done_cnt), 64'(dn0 + 1));
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        logic [63:0] exp1;
        logic [63:0] exp2;
        logic [60:0] rx_snap;
        int fr0;
        int dn0;

        // reset with start held high
        arstn   = 1'b0;
        b.start = 1'b1;
`ifdef SPI_TX_TRIG_ONLY_EN
        b.trig_only = 1'b0;
`endif
        rand_fields();
        repeat (3) tick();
        check("rst_sclk", 64'(b.sclk), 64'd0);
        check("rst_nss",  64'(b.nss),  64'd1);
        check("rst_mosi", 64'(b.mosi), 64'd0);
        check("rst_busy", 64'(b.busy), 64'd0);
        check("rst_done", 64'(b.done), 64'd0);
        b.start = 1'b0;
        arstn   = 1'b1;
        repeat (2) tick();
        check("idle_busy", 64'(b.busy), 64'd0);

        // directed frame
        b.trig      = 1'b1;
        b.adsr_ai   = 8'hA5;
        b.adsr_di   = 8'h3C;
        b.adsr_s    = 8'h80;
        b.adsr_ri   = 8'h0F;
        b.osc_count = 12'hABC;
        b.filter_a  = 8'h12;
        b.filter_b  = 8'h81;
        send_and_check("directed");

        // re-pulse start and change every field mid-frame
        exp1 = cur_word();
        fr0  = frames;
        dn0  = done_cnt;
        b.start = 1'b1;
        tick();
        b.start = 1'b0;
        wait_edges("midchg", 20);
        rand_fields();
        b.start = 1'b1;
        tick();
        b.start = 1'b0;
        wait_done("midchg", dn0);
        check_frame("midchg", exp1, FW);
        repeat (20) tick();
        check("midchg_frames", 64'(frames), 64'(fr0 + 1));
        check("midchg_done_once", 64'(done_cnt), 64'(dn0 + 1));
        check("midchg_idle", 64'(b.busy), 64'd0);

        // back-to-back frames with start held high
        rand_fields();
        exp1 = cur_word();
        dn0  = done_cnt;
        b.start = 1'b1;
        tick();
        wait_done("b2b_1", dn0);
        check_frame("b2b_1", exp1, FW);
        rand_fields();
        exp2 = cur_word();
        tick();
        check("b2b_busy_again", 64'(b.busy), 64'd1);
        b.start = 1'b0;
        dn0 = done_cnt;
        wait_done("b2b_2", dn0);
        check_frame("b2b_2", exp2, FW);
        check("b2b_gap", 64'(last_gap), 64'(GAP));
        check("b2b_busy_low", 64'(last_busy_lo), 64'd1);
        tick();

        // asynchronous reset in the middle of bit 30
        rand_fields();
        rx_snap = {rx_trig, rx_cfg};
        fr0 = frames;
        dn0 = done_cnt;
        b.start = 1'b1;
        tick();
        b.start = 1'b0;
        wait_edges("arst", 30);
        check("arst_in_high", 64'(b.sclk), 64'd1);
        arstn = 1'b0;
        #1;
        check("arst_sclk", 64'(b.sclk), 64'd0);
        check("arst_nss",  64'(b.nss),  64'd1);
        check("arst_busy", 64'(b.busy), 64'd0);
        tick();
        arstn = 1'b1;
        repeat (2) tick();
        check("arst_trunc_len", 64'(last_len), 64'd30);
        check("arst_frames", 64'(frames), 64'(fr0 + 1));
        check("arst_rx_kept", 64'({rx_trig, rx_cfg}), 64'(rx_snap));
        check("arst_no_done", 64'(done_cnt), 64'(dn0));
        send_and_check("after_arst");

        // random frames
        for (int i = 0; i < 4; i++) begin
            rand_fields();
            send_and_check("rand");
        end

`ifdef SPI_TX_TRIG_ONLY_EN
        // trigger-only frame
        rand_fields();
        b.trig      = 1'b1;
        b.trig_only = 1'b1;
        rx_snap = {rx_trig, rx_cfg};
        dn0 = done_cnt;
        b.start = 1'b1;
        tick();
        b.start = 1'b0;
        b.trig_only = 1'b0;
        wait_done("trigonly", dn0);
        check_frame("trigonly", 64'd0, 1);
        check("trigonly_nss_low", 64'(last_low), 64'd12);
        check("trigonly_rx_trig", 64'(rx_trig), 64'd1);
        check("trigonly_cfg_kept", 64'(rx_cfg), 64'(rx_snap[59:0]));
        rand_fields();
        send_and_check("after_trigonly");
`endif

        check("mosi_stable_sclk_high", 64'(viol), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
